sync_stream_decoder: RTL and testbench
======================================

Name: sync_stream_decoder

Overview:
- Receive-side counterpart of the camera-sync compander/emitter. Consumes the XB_SIZE-bit word stream that block produces: SOF header words plus per-patch words holding N_CAM compressed bytes.
- Re-frames the stream, tags each data beat with its patch index and frame number, and checks frame-number continuity, frame length and header integrity.
- Sits on the loopback/readback path for self-test and on the downstream consumer side in front of the decompander.

Parameters:
- DELAY, 1, simulation register delay on all non-blocking assignments.
- N_CAM, 3, cameras per data word.
- COMPRESS_SIZE, 8, bits per compressed sample.
- N_PATCH, 4096, data words per frame.
- N_FRAME_SIZE, 20, frame-number width in the SOF word.
- XB_SIZE, 32, stream word width. Must satisfy XB_SIZE >= N_CAM*COMPRESS_SIZE+8 and XB_SIZE >= N_FRAME_SIZE+12.
- CNT_SIZE, 16, error-counter width.

Ports:
- CLK, in, 1, clock.
- RESET, in, 1, synchronous, active-high.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, input word accepted when in_valid && in_ready.
- in_data, in, XB_SIZE, stream word.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts the beat.
- out_sof, out, 1, beat is a frame-start marker; carries no samples.
- out_last, out, 1, beat is data word N_PATCH-1 of the frame.
- out_patch, out, log2(N_PATCH), patch index of the data beat.
- out_frame, out, N_FRAME_SIZE, current frame number.
- out_mask, out, N_CAM, camera mask from the header byte.
- out_code, out, N_CAM*COMPRESS_SIZE, compressed samples, cam0 in the LSBs.
- in_frame, out, 1, state == INFRAME.
- orphan_cnt, gap_cnt, short_cnt, long_cnt, hdr_err_cnt, out, CNT_SIZE each, error counters.

Behaviour:
- Word decode. Header byte H = in_data[XB_SIZE-1 -: 8].
  - H[7] = EOF, H[6] = SOF, H[5:3] reserved (0), H[2:0] cam mask.
  - SOF word: in_data[XB_SIZE-1:XB_SIZE-2] = 2'b01; frame number in in_data[N_FRAME_SIZE-1:0].
  - EOF word: 2'b10.
  - Data word: 2'b00; samples in in_data[N_CAM*COMPRESS_SIZE-1:0].
  - 2'b11 is malformed: hdr_err_cnt++, word discarded.
- Handshake:
  - Single output register. in_ready = !out_valid || out_ready (combinational).
  - Latency 1: an accepted word that produces a beat has out_valid high the next cycle.
  - While out_valid && !out_ready, all outputs and state hold.
- States: WAIT_SOF and INFRAME. Reset enters WAIT_SOF. There is no lock-up error state; the block always resyncs.
- WAIT_SOF:
  - SOF word: latch frame number into out_frame; emit beat with out_sof=1; patch_cnt <= 0; go to INFRAME.
  - Gap check on SOF: if prev_valid and the number != prev+1 mod 2^N_FRAME_SIZE, gap_cnt++. Then prev <= number, prev_valid <= 1.
  - Data word: discard, orphan_cnt++.
  - EOF word: discard silently (optional terminator).
- INFRAME:
  - Data word: emit beat with out_patch=patch_cnt, out_code, out_mask; patch_cnt++.
  - On that data word, if mask != all-ones or reserved bits != 0, hdr_err_cnt++; the beat is still emitted.
  - When patch_cnt == N_PATCH-1 on the accepted data word: out_last=1, next state WAIT_SOF.
  - SOF word while in INFRAME (frame short): short_cnt++, then process as in WAIT_SOF (new frame, gap check, sof beat); stay INFRAME.
  - EOF word while in INFRAME: short_cnt++, go to WAIT_SOF, no beat.
- long_cnt: a data word arriving in WAIT_SOF within one accepted word after an out_last beat counts as long_cnt instead of orphan_cnt. Only the first such word counts as long; later ones count as orphan.
- Counters:
  - Saturate at all-ones and clear only on RESET.
  - At most one counter increments per accepted word.
- Reset (including mid-frame): out_valid=0, out_sof=0, out_last=0, out_patch=0, out_frame=0, out_mask=0, out_code=0, all counters 0, prev_valid=0, patch_cnt=0, state WAIT_SOF.
  - Hence the first SOF after reset never counts a gap.
- patch_cnt wrap: it returns to 0 only via a SOF word, never by overflow.

Test Plan (N_PATCH=4, N_CAM=3, XB_SIZE=32):
1. Frame 5 clean: SOF 0x40000005, then data 0x07030201, 0x07060504, 0x07090807, 0x070C0B0A.
   - Expect sof beat (out_frame=5), then 4 beats with out_patch 0..3 and out_code 0x030201..0x0C0B0A; out_last only on patch 3.
   - All counters 0; in_frame low afterward.
2. Gap: frame 5 complete, then SOF 0x40000007 → gap_cnt=1, out_frame=7. Then SOF for frame 8 after a complete frame 7 → gap_cnt stays 1.
3. Short/orphan:
   - Data word 0x07AABBCC before any SOF → orphan_cnt=1, no beat.
   - SOF(1), 2 data words, SOF(2) → short_cnt=1, new frame starts at out_patch 0.
   - EOF 0x80000000 mid-frame → short_cnt=2, in_frame=0.
4. Backpressure: hold out_ready=0 for 5 cycles during frame 1.
   - in_ready low while out_valid; beat contents held stable; no words lost or duplicated (patch 0..3 in order).
5. Header errors:
   - Data word 0x03112233 (mask 3'b011) → hdr_err_cnt=1, beat emitted with out_mask=3.
   - Word 0xC0000000 → hdr_err_cnt=2, discarded.
   - Extra data word after out_last → long_cnt=1.
6. Reset mid-frame after 2 data words, then SOF(9):
   - All outputs and counters 0 after reset.
   - SOF(9) gives gap_cnt=0 and out_frame=9.

Source files
------------

// File: rtl/sync_stream_decoder_if.sv
// Stream bundle for the sync stream decoder: word input handshake plus the tagged beat output.
// The slave modport is the decoder's view; the master modport is the surrounding producer/consumer.
interface sync_stream_decoder_if #(
  parameter int N_CAM         = 3,
  parameter int COMPRESS_SIZE = 8,
  parameter int N_PATCH       = 4096,
  parameter int N_FRAME_SIZE  = 20,
  parameter int XB_SIZE       = 32
) ();
  localparam int PW = (N_PATCH > 1) ? $clog2(N_PATCH) : 1;
  localparam int CW = N_CAM * COMPRESS_SIZE;

  logic                    in_valid;
  logic                    in_ready;
  logic [XB_SIZE-1:0]      in_data;

  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sof;
  logic                    out_last;
  logic [PW-1:0]           out_patch;
  logic [N_FRAME_SIZE-1:0] out_frame;
  logic [N_CAM-1:0]        out_mask;
  logic [CW-1:0]           out_code;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_sof,
    output out_last,
    output out_patch,
    output out_frame,
    output out_mask,
    output out_code
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_sof,
    input  out_last,
    input  out_patch,
    input  out_frame,
    input  out_mask,
    input  out_code
  );
endinterface

// File: rtl/sync_stream_decoder.sv
// Re-frames the compander word stream into tagged beats (sof / patch index / frame number)
// and counts framing faults: orphan data, frame-number gaps, short and long frames, bad headers.
//
// state    | meaning
// WAIT_SOF | between frames; data is orphan (or long right after a last beat)
// INFRAME  | SOF seen; data words are emitted with an incrementing patch index
module sync_stream_decoder #(
  parameter int DELAY         = 1,
  parameter int N_CAM         = 3,
  parameter int COMPRESS_SIZE = 8,
  parameter int N_PATCH       = 4096,
  parameter int N_FRAME_SIZE  = 20,
  parameter int XB_SIZE       = 32,
  parameter int CNT_SIZE      = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  sync_stream_decoder_if.slave       strm,
  output logic                       in_frame,
  output logic [CNT_SIZE-1:0]        orphan_cnt,
  output logic [CNT_SIZE-1:0]        gap_cnt,
  output logic [CNT_SIZE-1:0]        short_cnt,
  output logic [CNT_SIZE-1:0]        long_cnt,
  output logic [CNT_SIZE-1:0]        hdr_err_cnt
);
  localparam int PW = (N_PATCH > 1) ? $clog2(N_PATCH) : 1;
  localparam int CW = N_CAM * COMPRESS_SIZE;

  // The header byte only has room for three camera-mask bits.
  if (XB_SIZE < CW + 8 || XB_SIZE < N_FRAME_SIZE + 12 || N_CAM > 3 || N_CAM < 1 ||
      N_PATCH < 1 || DELAY < 0) begin : g_bad_param
    $error("sync_stream_decoder: illegal parameter combination");
  end

  typedef enum logic {
    WAIT_SOF = 1'b0,
    INFRAME  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           patch_cnt_q, patch_cnt_d;
  logic [N_FRAME_SIZE-1:0] prev_frame_q, prev_frame_d;
  logic                    prev_valid_q, prev_valid_d;
  logic                    long_arm_q, long_arm_d;

  logic                    out_valid_q, out_valid_d;
  logic                    out_sof_q, out_sof_d;
  logic                    out_last_q, out_last_d;
  logic [PW-1:0]           out_patch_q, out_patch_d;
  logic [N_FRAME_SIZE-1:0] out_frame_q, out_frame_d;
  logic [N_CAM-1:0]        out_mask_q, out_mask_d;
  logic [CW-1:0]           out_code_q, out_code_d;

  logic [CNT_SIZE-1:0]     orphan_cnt_q, orphan_cnt_d;
  logic [CNT_SIZE-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CNT_SIZE-1:0]     short_cnt_q, short_cnt_d;
  logic [CNT_SIZE-1:0]     long_cnt_q, long_cnt_d;
  logic [CNT_SIZE-1:0]     hdr_err_cnt_q, hdr_err_cnt_d;

  logic [7:0]              hdr;
  logic [1:0]              kind;
  logic [N_FRAME_SIZE-1:0] frame_num;
  logic [N_CAM-1:0]        mask_in;
  logic [CW-1:0]           code_in;
  logic                    hdr_ok;
  logic                    in_ready;
  logic                    accept;
  logic                    at_last;
  logic                    unused_in_bits;

  assign hdr       = strm.in_data[XB_SIZE-1 -: 8];
  assign kind      = hdr[7:6];
  assign frame_num = strm.in_data[N_FRAME_SIZE-1:0];
  assign mask_in   = hdr[N_CAM-1:0];
  assign code_in   = strm.in_data[CW-1:0];
  assign hdr_ok    = (&mask_in) && (hdr[5:3] == 3'b000);
  assign at_last   = (patch_cnt_q == PW'(N_PATCH - 1));

  // Middle bits of in_data are not defined by the word format.
  assign unused_in_bits = ^strm.in_data;

  assign in_ready = !out_valid_q || strm.out_ready;
  assign accept   = strm.in_valid && in_ready;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    patch_cnt_d   = patch_cnt_q;
    prev_frame_d  = prev_frame_q;
    prev_valid_d  = prev_valid_q;
    long_arm_d    = long_arm_q;
    out_valid_d   = out_valid_q && !strm.out_ready;
    out_sof_d     = out_sof_q;
    out_last_d    = out_last_q;
    out_patch_d   = out_patch_q;
    out_frame_d   = out_frame_q;
    out_mask_d    = out_mask_q;
    out_code_d    = out_code_q;
    orphan_cnt_d  = orphan_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    short_cnt_d   = short_cnt_q;
    long_cnt_d    = long_cnt_q;
    hdr_err_cnt_d = hdr_err_cnt_q;

    if (accept) begin
      // The long-frame window covers only the single word after a last beat.
      long_arm_d = 1'b0;
      unique case (kind)
        2'b11: hdr_err_cnt_d = sat_inc(hdr_err_cnt_q);

        2'b10: begin
          if (state_q == INFRAME) begin
            short_cnt_d = sat_inc(short_cnt_q);
            state_d     = WAIT_SOF;
          end
        end

        2'b01: begin
          // A short frame outranks a gap so only one counter moves per word.
          if (state_q == INFRAME) begin
            short_cnt_d = sat_inc(short_cnt_q);
          end else if (prev_valid_q &&
                       (frame_num != N_FRAME_SIZE'(prev_frame_q + 1'b1))) begin
            gap_cnt_d = sat_inc(gap_cnt_q);
          end
          prev_frame_d = frame_num;
          prev_valid_d = 1'b1;
          patch_cnt_d  = '0;
          state_d      = INFRAME;
          out_valid_d  = 1'b1;
          out_sof_d    = 1'b1;
          out_last_d   = 1'b0;
          out_patch_d  = '0;
          out_frame_d  = frame_num;
          out_mask_d   = mask_in;
          out_code_d   = '0;
        end

        default: begin
          if (state_q == INFRAME) begin
            if (!hdr_ok) begin
              hdr_err_cnt_d = sat_inc(hdr_err_cnt_q);
            end
            out_valid_d = 1'b1;
            out_sof_d   = 1'b0;
            out_last_d  = at_last;
            out_patch_d = patch_cnt_q;
            out_mask_d  = mask_in;
            out_code_d  = code_in;
            if (at_last) begin
              state_d    = WAIT_SOF;
              long_arm_d = 1'b1;
            end else begin
              patch_cnt_d = patch_cnt_q + 1'b1;
            end
          end else if (long_arm_q) begin
            long_cnt_d = sat_inc(long_cnt_q);
          end else begin
            orphan_cnt_d = sat_inc(orphan_cnt_q);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= WAIT_SOF;
      patch_cnt_q   <= '0;
      prev_frame_q  <= '0;
      prev_valid_q  <= 1'b0;
      long_arm_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_last_q    <= 1'b0;
      out_patch_q   <= '0;
      out_frame_q   <= '0;
      out_mask_q    <= '0;
      out_code_q    <= '0;
      orphan_cnt_q  <= '0;
      gap_cnt_q     <= '0;
      short_cnt_q   <= '0;
      long_cnt_q    <= '0;
      hdr_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      patch_cnt_q   <= patch_cnt_d;
      prev_frame_q  <= prev_frame_d;
      prev_valid_q  <= prev_valid_d;
      long_arm_q    <= long_arm_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
      out_last_q    <= out_last_d;
      out_patch_q   <= out_patch_d;
      out_frame_q   <= out_frame_d;
      out_mask_q    <= out_mask_d;
      out_code_q    <= out_code_d;
      orphan_cnt_q  <= orphan_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      short_cnt_q   <= short_cnt_d;
      long_cnt_q    <= long_cnt_d;
      hdr_err_cnt_q <= hdr_err_cnt_d;
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_sof   = out_sof_q;
  assign strm.out_last  = out_last_q;
  assign strm.out_patch = out_patch_q;
  assign strm.out_frame = out_frame_q;
  assign strm.out_mask  = out_mask_q;
  assign strm.out_code  = out_code_q;

  assign in_frame    = (state_q == INFRAME);
  assign orphan_cnt  = orphan_cnt_q;
  assign gap_cnt     = gap_cnt_q;
  assign short_cnt   = short_cnt_q;
  assign long_cnt    = long_cnt_q;
  assign hdr_err_cnt = hdr_err_cnt_q;
endmodule

// File: tb/tb_sync_stream_decoder.sv
// Bench for sync_stream_decoder with N_PATCH=4: directed words, expected beats queued at
// issue time and popped by an independent monitor; counters checked against hand values.
module tb_sync_stream_decoder;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_frame;
  logic [15:0] orphan_cnt, gap_cnt, short_cnt, long_cnt, hdr_err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        sof;
    logic        last;
    logic [1:0]  patch;
    logic [19:0] frame;
    logic [2:0]  mask;
    logic [23:0] code;
  } beat_t;

  beat_t exp_q[$];

  sync_stream_decoder_if #(.N_PATCH(4)) ifc ();

  sync_stream_decoder #(.N_PATCH(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .strm        (ifc),
    .in_frame    (in_frame),
    .orphan_cnt  (orphan_cnt),
    .gap_cnt     (gap_cnt),
    .short_cnt   (short_cnt),
    .long_cnt    (long_cnt),
    .hdr_err_cnt (hdr_err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnts(input int o, input int g, input int s, input int l, input int h);
    chk("orphan_cnt", {16'd0, orphan_cnt}, o);
    chk("gap_cnt", {16'd0, gap_cnt}, g);
    chk("short_cnt", {16'd0, short_cnt}, s);
    chk("long_cnt", {16'd0, long_cnt}, l);
    chk("hdr_err_cnt", {16'd0, hdr_err_cnt}, h);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] w);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = w;
    forever begin
      @(negedge CLK);
      if (ifc.in_ready) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: word %08h never accepted", w);
        break;
      end
    end
    @(posedge CLK);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic sof(input logic [19:0] f);
    beat_t b;
    b = '{sof: 1'b1, last: 1'b0, patch: 2'd0, frame: f, mask: 3'd0, code: 24'd0};
    exp_q.push_back(b);
    send(32'h4000_0000 | {12'd0, f});
  endtask

  task automatic data(input logic [1:0] p, input logic [19:0] f, input logic [31:0] w);
    beat_t b;
    b = '{sof: 1'b0, last: (p == 2'd3), patch: p, frame: f, mask: w[26:24], code: w[23:0]};
    exp_q.push_back(b);
    send(w);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", {31'd0, ifc.out_valid}, 0);
    chk("rst_out_sof", {31'd0, ifc.out_sof}, 0);
    chk("rst_out_last", {31'd0, ifc.out_last}, 0);
    chk("rst_out_patch", {30'd0, ifc.out_patch}, 0);
    chk("rst_out_frame", {12'd0, ifc.out_frame}, 0);
    chk("rst_out_mask", {29'd0, ifc.out_mask}, 0);
    chk("rst_out_code", {8'd0, ifc.out_code}, 0);
    chk("rst_in_frame", {31'd0, in_frame}, 0);
    chk("rst_in_ready", {31'd0, ifc.in_ready}, 1);
    chk_cnts(0, 0, 0, 0, 0);
  endtask

  // Monitor: pops on every transferred beat; while stalled, checks hold and in_ready.
  initial begin
    beat_t act, snap, e;
    bit held = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET && ifc.out_valid === 1'b1) begin
        act = '{sof: ifc.out_sof, last: ifc.out_last, patch: ifc.out_patch,
                frame: ifc.out_frame, mask: ifc.out_mask, code: ifc.out_code};
        if (held) begin
          total++;
          if (act !== snap) begin
            bad++;
            $display("FAIL beat_hold: got %h expected %h", act, snap);
          end
        end
        if (ifc.out_ready !== 1'b1) begin
          total++;
          if (ifc.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL in_ready_stall: got %b expected 0", ifc.in_ready);
          end
          held = 1'b1;
          snap = act;
        end else begin
          held = 1'b0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got %h expected none", act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              bad++;
              $display("FAIL beat: got %h expected %h", act, e);
            end
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    do_reset();
    chk_reset_state();

    // 1: clean frame 5
    sof(20'd5);
    chk("t1_out_frame", {12'd0, ifc.out_frame}, 5);
    data(2'd0, 20'd5, 32'h0703_0201);
    data(2'd1, 20'd5, 32'h0706_0504);
    data(2'd2, 20'd5, 32'h0709_0807);
    data(2'd3, 20'd5, 32'h070C_0B0A);
    chk("t1_in_frame", {31'd0, in_frame}, 0);
    chk_cnts(0, 0, 0, 0, 0);

    // 2: frame 7 skips 6; frame 8 follows cleanly
    sof(20'd7);
    chk("t2_gap_cnt", {16'd0, gap_cnt}, 1);
    chk("t2_out_frame", {12'd0, ifc.out_frame}, 7);
    data(2'd0, 20'd7, 32'h0700_0070);
    data(2'd1, 20'd7, 32'h0700_0071);
    data(2'd2, 20'd7, 32'h0700_0072);
    data(2'd3, 20'd7, 32'h0700_0073);
    sof(20'd8);
    chk_cnts(0, 1, 0, 0, 0);

    // 3: orphan, short by SOF, short by EOF
    do_reset();
    send(32'h07AA_BBCC);
    chk_cnts(1, 0, 0, 0, 0);
    sof(20'd1);
    data(2'd0, 20'd1, 32'h0700_0011);
    data(2'd1, 20'd1, 32'h0700_0012);
    sof(20'd2);
    chk("t3_short_sof", {16'd0, short_cnt}, 1);
    data(2'd0, 20'd2, 32'h0700_0021);
    send(32'h8000_0000);
    chk("t3_in_frame", {31'd0, in_frame}, 0);
    chk_cnts(1, 0, 2, 0, 0);

    // 4: downstream stalls for 5 cycles right after the SOF beat
    fork
      begin
        sof(20'd3);
        data(2'd0, 20'd3, 32'h0700_0031);
        data(2'd1, 20'd3, 32'h0700_0032);
        data(2'd2, 20'd3, 32'h0700_0033);
        data(2'd3, 20'd3, 32'h0700_0034);
      end
      begin
        ifc.out_ready = 1'b0;
        repeat (5) begin
          @(posedge CLK);
          #1;
        end
        ifc.out_ready = 1'b1;
      end
    join
    chk_cnts(1, 0, 2, 0, 0);

    // 5: partial mask, malformed word, long frame, then orphan
    sof(20'd4);
    data(2'd0, 20'd4, 32'h0311_2233);
    chk("t5_hdr_mask", {16'd0, hdr_err_cnt}, 1);
    send(32'hC000_0000);
    chk("t5_hdr_malformed", {16'd0, hdr_err_cnt}, 2);
    data(2'd1, 20'd4, 32'h0700_0001);
    data(2'd2, 20'd4, 32'h0700_0002);
    data(2'd3, 20'd4, 32'h0700_0003);
    send(32'h0712_3456);
    send(32'h0765_4321);
    chk_cnts(2, 0, 2, 1, 2);

    // 6: reset mid-frame, then the first SOF never counts a gap
    sof(20'd5);
    data(2'd0, 20'd5, 32'h0700_0101);
    data(2'd1, 20'd5, 32'h0700_0102);
    do_reset();
    chk_reset_state();
    sof(20'd9);
    chk("t6_out_frame", {12'd0, ifc.out_frame}, 9);
    chk("t6_in_frame", {31'd0, in_frame}, 1);
    chk_cnts(0, 0, 0, 0, 0);

    repeat (5) @(posedge CLK);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
